// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_code_t;

  // PS/2 frames use odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// First-word-fall-through FIFO with occupancy and a sticky overflow flag.
module ps2_code_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     ovf_clr_i,
  output logic                     rd_valid_o,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              LW       = AW + 1;
  localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]               level_q;
  logic                        overflow_q;
  logic                        empty_s, full_s, pop_s, push_s, drop_s;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
  always_comb begin
    empty_s = (level_q == '0);
    full_s  = (level_q == FULL_LVL);
    pop_s   = pop_i && !empty_s;
    push_s  = push_i && (!full_s || pop_s);
    drop_s  = push_i && full_s && !pop_s;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop_s) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign rd_valid_o = !empty_s;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin conditioning, frame FSM with watchdog,
// optional E0/F0 prefix folding and a code FIFO.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int DEPTH       = 16,
  parameter int DECODE      = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic                   PS2_CLK,
  input  logic                   PS2_DAT,
  input  logic                   rd_en,
  input  logic                   ovf_clr,
  output logic                   rd_valid,
  output logic [9:0]             rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   err_parity,
  output logic                   err_frame,
  output logic                   err_timeout,
  output logic [7:0]             err_cnt,
  output logic                   busy
);

  localparam int             FCW     = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FILTER_LEN - 1);
  localparam int             WDW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYC);

  // Line index 0 is PS2_CLK, index 1 is PS2_DAT.
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0][FCW-1:0]         fcnt_q;
  logic [1:0]                  filt_q;
  logic                        clk_prev_q;
  logic [1:0]                  pin_s;
  logic                        strobe_s, dat_s;

  assign pin_s = {PS2_DAT, PS2_CLK};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q     <= '1;
      fcnt_q     <= '0;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pin_s[i]};
        // The filtered level only flips after FILTER_LEN consecutive disagreeing samples.
        if (sync_q[i][SYNC_STAGES-1] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FC_LAST) begin
          filt_q[i] <= sync_q[i][SYNC_STAGES-1];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign strobe_s = clk_prev_q & ~filt_q[0];
  assign dat_s    = filt_q[1];

  rx_state_t      state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           valid_s, perr_s, ferr_s, terr_s;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    valid_s   = 1'b0;
    perr_s    = 1'b0;
    ferr_s    = 1'b0;
    terr_s    = 1'b0;
    wd_d      = (state_q == ST_IDLE || strobe_s) ? '0 : wd_q + 1'b1;
    if (state_q != ST_IDLE && wd_q == WD_MAX) begin
      state_d = ST_IDLE;
      terr_s  = 1'b1;
      wd_d    = '0;
    end else if (strobe_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == 3'd7) ? ST_PARITY : ST_DATA;
        end
        ST_PARITY: begin
          par_d   = dat_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!dat_s) begin
            ferr_s = 1'b1;
          end else if (!odd_parity_ok(shift_q, par_q)) begin
            perr_s = 1'b1;
          end else begin
            valid_s = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  logic      ext_q, ext_d, brk_q, brk_d, push_q, push_d;
  ps2_code_t code_q, code_d;
  logic      err_any_s;

  assign err_any_s = perr_s | ferr_s | terr_s;

  // Prefix bytes only arm flags; any error discards a half-assembled sequence.
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    push_d = 1'b0;
    code_d = code_q;
    if (err_any_s) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (valid_s) begin
      if (DECODE != 0 && shift_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (DECODE != 0 && shift_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        push_d = 1'b1;
        code_d = '{ext: ext_q, brk: brk_q, code: shift_q};
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end
    end else begin
      push_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      wd_q        <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      push_q      <= 1'b0;
      code_q      <= '0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      wd_q        <= wd_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      push_q      <= push_d;
      code_q      <= code_d;
      err_parity  <= perr_s;
      err_frame   <= ferr_s;
      err_timeout <= terr_s;
      if (err_any_s && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end else begin
        err_cnt <= err_cnt;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

  ps2_code_fifo #(
    .WIDTH(10),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (CLOCK_50),
    .rst_ni     (RESET_N),
    .push_i     (push_q),
    .push_data_i(code_q),
    .pop_i      (rd_en),
    .ovf_clr_i  (ovf_clr),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .level_o    (level),
    .overflow_o (overflow)
  );

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench: a raw (DECODE=0) and a folding (DECODE=1) receiver share the PS/2 pins.
module tb_ps2_rx;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  logic PS2_CLK  = 1'b1;
  logic PS2_DAT  = 1'b1;
  logic raw_rd_en = 1'b0, dec_rd_en = 1'b0, ovf_clr = 1'b0;

  logic       raw_rd_valid, raw_overflow, raw_err_parity, raw_err_frame, raw_err_timeout, raw_busy;
  logic [9:0] raw_rd_data;
  logic [2:0] raw_level;
  logic [7:0] raw_err_cnt;
  logic       dec_rd_valid, dec_overflow, dec_err_parity, dec_err_frame, dec_err_timeout, dec_busy;
  logic [9:0] dec_rd_data;
  logic [2:0] dec_level;
  logic [7:0] dec_err_cnt;

  int checks = 0;
  int errors = 0;
  int n_perr = 0, n_ferr = 0, n_tmo = 0;

  ps2_rx #(.SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYC(1000), .DEPTH(4), .DECODE(0)) u_raw (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .rd_en(raw_rd_en), .ovf_clr(ovf_clr), .rd_valid(raw_rd_valid), .rd_data(raw_rd_data),
    .level(raw_level), .overflow(raw_overflow), .err_parity(raw_err_parity),
    .err_frame(raw_err_frame), .err_timeout(raw_err_timeout), .err_cnt(raw_err_cnt),
    .busy(raw_busy));

  ps2_rx #(.SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYC(1000), .DEPTH(4), .DECODE(1)) u_dec (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .rd_en(dec_rd_en), .ovf_clr(ovf_clr), .rd_valid(dec_rd_valid), .rd_data(dec_rd_data),
    .level(dec_level), .overflow(dec_overflow), .err_parity(dec_err_parity),
    .err_frame(dec_err_frame), .err_timeout(dec_err_timeout), .err_cnt(dec_err_cnt),
    .busy(dec_busy));

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (dec_err_parity)  n_perr <= n_perr + 1;
    if (dec_err_frame)   n_ferr <= n_ferr + 1;
    if (dec_err_timeout) n_tmo  <= n_tmo + 1;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    repeat (20) @(negedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (40) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
    repeat (20) @(negedge CLOCK_50);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    PS2_DAT = 1'b1;
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  task automatic pop(input logic do_raw, input logic do_dec);
    raw_rd_en = do_raw;
    dec_rd_en = do_dec;
    @(negedge CLOCK_50);
    raw_rd_en = 1'b0;
    dec_rd_en = 1'b0;
  endtask

  initial begin
    int p0, waited;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_rd_valid", {31'd0, dec_rd_valid}, 32'd0);
    chk("rst_level",    {29'd0, dec_level}, 32'd0);
    chk("rst_rd_data",  {22'd0, dec_rd_data}, 32'd0);
    chk("rst_overflow", {31'd0, dec_overflow}, 32'd0);
    chk("rst_err",      {29'd0, dec_err_parity, dec_err_frame, dec_err_timeout}, 32'd0);
    chk("rst_err_cnt",  {24'd0, dec_err_cnt}, 32'd0);
    chk("rst_busy",     {31'd0, dec_busy}, 32'd0);
    chk("rst_raw_lvl",  {29'd0, raw_level}, 32'd0);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    // raw byte 0x1C
    send(8'h1C);
    chk("raw1c_data",  {22'd0, raw_rd_data}, 32'h01C);
    chk("raw1c_level", {29'd0, raw_level}, 32'd1);
    chk("raw1c_errs",  {24'd0, raw_err_cnt}, 32'd0);
    chk("dec1c_data",  {22'd0, dec_rd_data}, 32'h01C);
    pop(1'b1, 1'b1);
    chk("raw1c_empty", {31'd0, raw_rd_valid}, 32'd0);
    chk("dec1c_empty", {31'd0, dec_rd_valid}, 32'd0);

    // extended break sequence E0 F0 75
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("fold_level", {29'd0, dec_level}, 32'd1);
    chk("fold_data",  {22'd0, dec_rd_data}, 32'h375);
    pop(1'b1, 1'b1);
    chk("fold_empty", {31'd0, dec_rd_valid}, 32'd0);
    chk("raw_fold_level", {29'd0, raw_level}, 32'd2);
    chk("raw_fold_d1", {22'd0, raw_rd_data}, 32'h0F0);
    pop(1'b1, 1'b0);
    chk("raw_fold_d2", {22'd0, raw_rd_data}, 32'h075);
    pop(1'b1, 1'b0);

    // bad parity then good byte
    p0 = n_perr;
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    chk("par_pulses",  n_perr - p0, 32'd1);
    chk("par_level",   {29'd0, dec_level}, 32'd0);
    chk("par_err_cnt", {24'd0, dec_err_cnt}, 32'd1);
    chk("par_raw_cnt", {24'd0, raw_err_cnt}, 32'd1);
    send(8'h1C);
    chk("par_good", {22'd0, dec_rd_data}, 32'h01C);
    pop(1'b1, 1'b1);

    // frame error clears a pending E0 prefix
    p0 = n_ferr;
    send(8'hE0);
    send_frame(8'h42, 1'b0, 1'b0, 11);
    chk("frm_pulses",  n_ferr - p0, 32'd1);
    chk("frm_err_cnt", {24'd0, dec_err_cnt}, 32'd2);
    send(8'h11);
    chk("frm_after", {22'd0, dec_rd_data}, 32'h011);
    chk("frm_level", {29'd0, dec_level}, 32'd1);
    pop(1'b1, 1'b1);
    chk("frm_raw_next", {22'd0, raw_rd_data}, 32'h011);
    pop(1'b1, 1'b0);

    // watchdog after 5 bits
    p0 = n_tmo;
    send_frame(8'hAA, 1'b0, 1'b1, 5);
    chk("tmo_busy_before", {31'd0, dec_busy}, 32'd1);
    waited = 0;
    while (n_tmo == p0 && waited < 1500) begin
      @(negedge CLOCK_50);
      waited++;
    end
    chk("tmo_pulses", n_tmo - p0, 32'd1);
    chk("tmo_delay_ok", {31'd0, (waited >= 900 && waited <= 1010)}, 32'd1);
    chk("tmo_busy_after", {31'd0, dec_busy}, 32'd0);
    chk("tmo_err_cnt", {24'd0, dec_err_cnt}, 32'd3);
    send(8'h29);
    chk("tmo_good", {22'd0, dec_rd_data}, 32'h029);
    chk("tmo_level", {29'd0, dec_level}, 32'd1);
    pop(1'b1, 1'b1);

    // overflow with DEPTH=4
    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("ovf_level", {29'd0, dec_level}, 32'd4);
    chk("ovf_flag",  {31'd0, dec_overflow}, 32'd1);
    chk("ovf_raw_flag", {31'd0, raw_overflow}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_pop", {22'd0, dec_rd_data}, 32'(i));
      pop(1'b1, 1'b1);
    end
    chk("ovf_drained", {29'd0, dec_level}, 32'd0);
    chk("ovf_sticky",  {31'd0, dec_overflow}, 32'd1);
    ovf_clr = 1'b1;
    @(negedge CLOCK_50);
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, dec_overflow}, 32'd0);

    // reset in the middle of a frame
    send(8'h33);
    send_frame(8'hC3, 1'b0, 1'b1, 6);
    chk("mid_busy", {31'd0, dec_busy}, 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, dec_rd_valid}, 32'd0);
    chk("mid_rst_level", {29'd0, dec_level}, 32'd0);
    chk("mid_rst_data",  {22'd0, dec_rd_data}, 32'd0);
    chk("mid_rst_cnt",   {24'd0, dec_err_cnt}, 32'd0);
    chk("mid_rst_busy",  {31'd0, dec_busy}, 32'd0);
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    send(8'h5A);
    chk("post_rst_data",  {22'd0, dec_rd_data}, 32'h05A);
    chk("post_rst_level", {29'd0, dec_level}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

Parametrised PS/2 device-to-host receiver, the successor to `ps2ctrlr`, sitting between the board PS/2 pins and keyboard-consuming logic.
- Synchronises and glitch-filters `PS2_CLK`/`PS2_DAT`, deframes 11-bit frames, checks parity and stop bit, and aborts stalled frames on a watchdog.
- Buffers received codes in a configurable FIFO.
- Optionally folds E0/F0 prefixes into tagged make/break events.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops per PS/2 input (≥2).
- `FILTER_LEN`, 8: consecutive equal synchronised samples needed to change a filtered level (≥1).
- `TIMEOUT_CYC`, 100000: `CLOCK_50` cycles allowed between falling edges inside a frame (2 ms at 50 MHz).
- `DEPTH`, 16: FIFO entries, power of 2, ≥2.
- `DECODE`, 1: 0 = raw bytes; 1 = prefix folding.
- `CLOCK_50  in  1`  system clock.
- `RESET_N  in  1`  reset. One clock; reset is asynchronous and active-low.
- `PS2_CLK  in  1`  PS/2 clock pin, asynchronous.
- `PS2_DAT  in  1`  PS/2 data pin, asynchronous.
- `rd_en  in  1`  pop request.
- `ovf_clr  in  1`  clears `overflow`.
- `rd_valid  out  1`  FIFO non-empty.
- `rd_data  out  10`  head entry `{ext, brk, code[7:0]}`.
- `level  out  $clog2(DEPTH)+1`  occupancy.
- `overflow  out  1`  sticky: a code was dropped.
- `err_parity  out  1`  1-cycle pulse.
- `err_frame  out  1`  1-cycle pulse: stop bit is 0.
- `err_timeout  out  1`  1-cycle pulse.
- `err_cnt  out  8`  saturating total of all error pulses.
- `busy  out  1`  frame in progress.

## Operation
- Input path: `SYNC_STAGES` flops, then a per-line filter counter. Filtered lines reset to 1. A falling edge of filtered `PS2_CLK` is a sample strobe.
- FSM states are IDLE, DATA, PARITY and STOP.
  - IDLE: a strobe with DAT=0 goes to DATA, bit count 0. A strobe with DAT=1 is a spurious start: ignored, no error.
  - DATA: each strobe shifts DAT in LSB first. The 8th bit moves the FSM to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: DAT=1 and odd parity over data+parity gives a valid byte. DAT=0 gives `err_frame`. Bad parity with a good stop gives `err_parity`. Frame error takes precedence. The FSM always returns to IDLE.
- `busy` = state ≠ IDLE.
- Watchdog: counter cleared on every strobe and held at 0 in IDLE. Reaching `TIMEOUT_CYC` in any other state forces IDLE, pulses `err_timeout` and discards the partial byte.
- Decoder with `DECODE=1`:
  - 8'hE0 sets `ext`; 8'hF0 sets `brk`. Neither is pushed.
  - Any other valid byte pushes `{ext, brk, byte}` and clears both flags.
  - Any error pulse clears both flags.
- Decoder with `DECODE=0`: every valid byte is pushed as `{2'b00, byte}`.
- FIFO: first-word-fall-through.
  - `rd_data` always shows the head entry.
  - A pop occurs when `rd_en && rd_valid`. `rd_en` while empty is ignored.
  - A push while full with no pop in the same cycle drops the code and sets `overflow`.
  - A push and a pop in the same cycle while full are both accepted, with no overflow.
- `ovf_clr` clears `overflow`. A simultaneous overflow event wins, leaving `overflow`=1.
- `err_cnt` counts up to 255 and holds there.

## Timing
- Reset values:
  - FSM in IDLE; filtered lines at 1.
  - `rd_valid`=0, `level`=0, `rd_data`=0.
  - `overflow`=0, all `err_*`=0, `err_cnt`=0, `busy`=0.
- Strobe latency: the strobe occurs `SYNC_STAGES+FILTER_LEN` cycles after a pin falling edge, ±1 cycle.
- Stop-bit strobe to FIFO visibility:
  - Stop-bit strobe cycle N: error pulse (if any) at N+1.
  - Push at N+1.
  - `rd_valid`/`level` updated at N+2.
- A pop in cycle M gives the new head and `level` at M+1.
- Reset asserted mid-frame returns everything asynchronously to the reset values. The first frame after release is received normally.
- PS/2 rates are 10–16.7 kHz, so no back-to-back strobe hazard exists. A FIFO push and pop may still coincide in any cycle.

## Structure
- `ps2_pkg` holds:
  - the `rx_state_t` enum;
  - `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0;
  - `PS2_FRAME_BITS`=11;
  - the `ps2_code_t` packed struct `{ext, brk, code}`.
- Sub-module `ps2_code_fifo`: parametrised width/depth FWFT FIFO with level and overflow. Synchroniser, filter, FSM, watchdog and decoder stay in `ps2_rx`.

## Test plan
- Raw 0x1C (parity 0, stop 1) with `DECODE=0`: `rd_data`=10'h01C, `level`=1, no errors. A pop then gives `rd_valid`=0.
- E0, F0, 0x75 with `DECODE=1`: exactly one entry, 10'h375, `level`=1.
- 0x1C sent with parity 1: nothing pushed, one `err_parity` pulse, `err_cnt`=1. A following good 0x1C is received as 10'h01C.
- 5 bits, then `PS2_CLK` idle high, with `TIMEOUT_CYC`=1000:
  - `err_timeout` pulses ~1000 cycles after the last strobe and `busy`=0.
  - A following good 0x29 is received as 10'h029.
- `DEPTH`=4, bytes 0x01–0x05 with no reads:
  - `level`=4, `overflow`=1, pops return 0x01–0x04.
  - `ovf_clr` then clears `overflow`.
- `RESET_N` pulsed low after 6 bits of a frame: all outputs return to reset values, then a good 0x5A is received as 10'h05A.
